led_shift_stage: RTL

- Consumes the rate strobe from the rate counter stage (its o_valid) and advances a one-hot LED pattern by one position per strobe.
- Supports hold, rotate-left, rotate-right and ping-pong (bounce) modes, selected by switches, plus a synchronous reload to the seed pattern.
- Sits directly downstream of the counter and drives the board LEDs.
- Emits a one-cycle wrap/turn pulse for downstream status logic.

---
 rtl/led_shift_stage_pkg.sv | 23 ++
 rtl/led_shift_stage_edge_detect.sv | 40 ++++
 rtl/led_shift_stage.sv | 130 +++++++++++++
 3 files changed

// File: rtl/led_shift_stage_pkg.sv
// ----------------------------------------------------------------------------
// led_shift_stage_pkg
//   Shared constants for the LED shift stage and its strobe edge detector:
//   mode encodings, ping-pong direction encodings and the seed position.
//   No ports; imported with "import led_shift_stage_pkg::*;".
// ----------------------------------------------------------------------------
package led_shift_stage_pkg;

   // Mode select encodings (2-bit field of i_mode).
   localparam logic [1:0] MODE_HOLD  = 2'b00;
   localparam logic [1:0] MODE_ROT_L = 2'b01;
   localparam logic [1:0] MODE_ROT_R = 2'b10;
   localparam logic [1:0] MODE_PING  = 2'b11;

   // Ping-pong direction states, held in the dir register.
   // LEFT moves toward the MSB, RIGHT moves toward the LSB.
   localparam logic DIR_LEFT  = 1'b0;
   localparam logic DIR_RIGHT = 1'b1;

   // Bit position lit by the seed pattern (reset and reload value).
   localparam int unsigned SEED_INDEX = 32'd0;

endpackage : led_shift_stage_pkg

// File: rtl/led_shift_stage_edge_detect.sv
// ----------------------------------------------------------------------------
// led_shift_stage_edge_detect
//   Turns a level strobe into a single-cycle step pulse on its rising edge,
//   so a strobe held high for many cycles is consumed exactly once.
//   The step pulse is combinational from i_sig so that the consumer can act
//   on the very clock edge that first samples i_sig high.
//
// Ports:
//   clock    in  1  system clock
//   i_reset  in  1  asynchronous active-low reset
//   i_sig    in  1  level strobe to be edge-detected
//   o_step   out 1  i_sig & ~(i_sig delayed by one cycle)
// ----------------------------------------------------------------------------
module led_shift_stage_edge_detect (
   input  logic clock,
   input  logic i_reset,
   input  logic i_sig,
   output logic o_step
);

   logic valid_d;
   logic valid_q;

   // Next value of the delayed strobe: always follows the input.
   always_comb begin
      valid_d = i_sig;
   end

   // Delayed copy of the strobe, cleared asynchronously by reset.
   always_ff @(posedge clock or negedge i_reset) begin
      if (!i_reset) begin
         valid_q <= 1'b0;
      end else begin
         valid_q <= valid_d;
      end
   end

   assign o_step = i_sig & ~valid_q;

endmodule : led_shift_stage_edge_detect

// File: rtl/led_shift_stage.sv
// ----------------------------------------------------------------------------
// led_shift_stage
//   Advances a one-hot LED pattern by one position per rising edge of the
//   upstream rate strobe. Modes: hold, rotate left, rotate right and
//   ping-pong. i_load reloads the seed pattern and takes priority over a step.
//   o_wrap pulses for one cycle on a rotate wrap-around or a ping-pong turn.
//
// Ports:
//   clock    in  1        system clock, rising edge
//   i_reset  in  1        asynchronous active-low reset
//   i_valid  in  1        rate strobe (may stay high for many cycles)
//   i_mode   in  NB_MODE  00 hold, 01 rotate left, 10 rotate right, 11 ping-pong
//   i_load   in  1        synchronous reload of seed pattern and direction
//   o_led    out NB_LEDS  one-hot LED pattern (registered)
//   o_dir    out 1        ping-pong direction, 0 = left (toward MSB), 1 = right
//   o_wrap   out 1        one-cycle wrap/turn pulse (registered)
// ----------------------------------------------------------------------------
module led_shift_stage
   import led_shift_stage_pkg::*;
#(
   parameter int NB_LEDS = 4,
   parameter int NB_MODE = 2
) (
   input  logic               clock,
   input  logic               i_reset,
   input  logic               i_valid,
   input  logic [NB_MODE-1:0] i_mode,
   input  logic               i_load,
   output logic [NB_LEDS-1:0] o_led,
   output logic               o_dir,
   output logic               o_wrap
);

   localparam logic [NB_LEDS-1:0] SEED = {{(NB_LEDS-1){1'b0}}, 1'b1} << SEED_INDEX;

   logic               step_s;
   logic [1:0]         mode_s;

   logic [NB_LEDS-1:0] led_d;
   logic [NB_LEDS-1:0] led_q;
   logic               dir_d;
   logic               dir_q;
   logic               wrap_d;
   logic               wrap_q;

   // Only the two low mode bits carry an encoding.
   assign mode_s = i_mode[1:0];

   led_shift_stage_edge_detect u_edge_detect (
      .clock   (clock),
      .i_reset (i_reset),
      .i_sig   (i_valid),
      .o_step  (step_s)
   );

   // Next pattern, direction and wrap pulse: load beats step beats hold.
   always_comb begin
      led_d  = led_q;
      dir_d  = dir_q;
      wrap_d = 1'b0;

      if (i_load) begin
         led_d  = SEED;
         dir_d  = DIR_LEFT;
         wrap_d = 1'b0;
      end else if (step_s) begin
         case (mode_s)
            MODE_HOLD: begin
               led_d  = led_q;
               wrap_d = 1'b0;
            end
            MODE_ROT_L: begin
               led_d  = {led_q[NB_LEDS-2:0], led_q[NB_LEDS-1]};
               wrap_d = led_q[NB_LEDS-1];
            end
            MODE_ROT_R: begin
               led_d  = {led_q[0], led_q[NB_LEDS-1:1]};
               wrap_d = led_q[0];
            end
            MODE_PING: begin
               // Ping-pong shifts (never rotates); at the end being faced it
               // turns and moves one step back inward in the same update.
               if (dir_q == DIR_LEFT) begin
                  if (led_q[NB_LEDS-1]) begin
                     dir_d  = DIR_RIGHT;
                     led_d  = {1'b0, led_q[NB_LEDS-1:1]};
                     wrap_d = 1'b1;
                  end else begin
                     led_d  = {led_q[NB_LEDS-2:0], 1'b0};
                  end
               end else begin
                  if (led_q[0]) begin
                     dir_d  = DIR_LEFT;
                     led_d  = {led_q[NB_LEDS-2:0], 1'b0};
                     wrap_d = 1'b1;
                  end else begin
                     led_d  = {1'b0, led_q[NB_LEDS-1:1]};
                  end
               end
            end
            default: begin
               led_d  = led_q;
               wrap_d = 1'b0;
            end
         endcase
      end else begin
         led_d  = led_q;
         dir_d  = dir_q;
         wrap_d = 1'b0;
      end
   end

   // Pattern, direction and wrap registers with asynchronous reset to seed.
   always_ff @(posedge clock or negedge i_reset) begin
      if (!i_reset) begin
         led_q  <= SEED;
         dir_q  <= DIR_LEFT;
         wrap_q <= 1'b0;
      end else begin
         led_q  <= led_d;
         dir_q  <= dir_d;
         wrap_q <= wrap_d;
      end
   end

   assign o_led  = led_q;
   assign o_dir  = dir_q;
   assign o_wrap = wrap_q;

endmodule : led_shift_stage
